rx_frame_receiver: RTL and testbench
====================================

Name: rx_frame_receiver

Overview:
- Receiving end of the single-wire serial frame link whose transmitter serialises one BIT_LEN-bit word per frame, one bit per clk, in the same clock domain.
- Watches the idle-low line for a start bit, deserialises parity, data and stop bits, and checks parity and framing.
- Presents each received word with a one-cycle valid strobe and error flags to downstream logic.

Parameters:
- BIT_LEN, 7, data bits per frame; must be >= 1.

Ports:
- clk  input  1  clock; all sampling on the rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- channel_in  input  1  serial line; 0 when idle; driven from the transmitter's registers in the clk domain, so no synchroniser.
- data_out  output  BIT_LEN  last received word; held until the next frame completes.
- data_valid  output  1  one-cycle pulse: frame complete, data_out and flags updated.
- parity_err  output  1  registered with data_valid; received parity != XOR of received data bits.
- frame_err  output  1  registered with data_valid; at least one stop bit sampled 0.
- busy  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- Frame on the line, one bit per clk, in order:
  - start bit = 1
  - parity bit = XOR of the data bits (even parity over data plus parity)
  - BIT_LEN data bits, LSB first
  - two stop bits = 1
  - the line then returns to 0.
- Frame length is BIT_LEN+4 bits, so 11 bits at the default.
- Reset (rstn low, asynchronous):
  - state = IDLE; shift register, bit counter, data_out, data_valid, parity_err and frame_err = 0; busy = 0.
  - Reset asserted mid-frame aborts the frame: no data_valid, no flag update. Reception restarts from IDLE after release.
- States: IDLE, PARITY, DATA, STOP1, STOP2.
  - IDLE: channel_in sampled 1 at edge E0 -> PARITY. A sampled 0 stays in IDLE.
  - PARITY: store channel_in as rx_parity at E1 -> DATA; bit counter = 0.
  - DATA: at each edge store channel_in into data bit [counter], then counter+1. After bit BIT_LEN-1 (edge E(BIT_LEN+1)) -> STOP1. Counter width $clog2(BIT_LEN+1); it never wraps.
  - STOP1: record stop1 = channel_in -> STOP2.
  - STOP2: sample stop2 at edge E(BIT_LEN+3) -> IDLE. On that same edge:
    - data_out <= received word
    - parity_err <= rx_parity ^ (^received word)
    - frame_err <= ~(stop1 & stop2)
    - data_valid <= 1
- Latency: data_valid is high for exactly the clk cycle following edge E(BIT_LEN+3), i.e. E0+10 at the default. It is cleared on the next edge.
- parity_err and frame_err hold their values until the next data_valid. data_valid also fires when either flag is set. data_out is updated even on error.
- Stop bits are not used for resynchronisation. A 0 in STOP1 does not abort the frame; both stop positions are always consumed.
- Back-to-back frames:
  - The cycle after STOP2 is evaluated in IDLE.
  - A 1 there (no idle gap) is a new start bit and must be accepted.
  - The transmitter's normal minimum gap of 1 idle cycle must also work.
- Line stuck high: frames repeat every BIT_LEN+4 cycles, each with parity/data all 1s and stop bits 1. parity_err = ~^(all ones) ^ 1; no lockup.
- busy = 1 from the edge after start detection through the STOP2 cycle, then 0 in the cycle data_valid is high.

Test Plan:
- Reset, line held 0 for 20 cycles -> data_valid never pulses; all outputs 0; busy 0.
- Frame 7'h55: line 1,0,1,0,1,0,1,0,1,1,1 -> one data_valid pulse 10 cycles after the start-bit edge; data_out=7'h55, parity_err=0, frame_err=0.
- Frame 7'h01 sent with wrong parity bit 0: line 1,0,1,0,0,0,0,0,0,1,1 -> data_out=7'h01, parity_err=1, frame_err=0.
- Frame 7'h7F with second stop bit forced 0 -> data_out=7'h7F, parity_err=0, frame_err=1; next good frame 7'h2A clears both flags.
- Back-to-back 7'h12 then 7'h6C with 0-cycle and 1-cycle gaps -> two data_valid pulses 11 (resp. 12) cycles apart, correct data and no errors on both.
- rstn pulsed low during DATA bit 3 of a frame, then a clean 7'h33 frame -> no valid for the aborted frame; outputs 0 during reset; 7'h33 received with no errors.

Source files
------------

// File: rtl/rx_frame_receiver.sv
// Receiver for the single-wire serial frame link (same clock domain as the transmitter).
// Frame: start(1), parity, BIT_LEN data bits LSB first, two stop bits(1).
// Each completed frame presents data_out with a one-cycle data_valid strobe and
// parity/framing error flags that hold until the next frame completes.
module rx_frame_receiver #(
    parameter int BIT_LEN = 7
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               channel_in,
    output logic [BIT_LEN-1:0] data_out,
    output logic               data_valid,
    output logic               parity_err,
    output logic               frame_err,
    output logic               busy
);

    localparam int CW = $clog2(BIT_LEN + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(BIT_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        PARITY,
        DATA,
        STOP1,
        STOP2
    } state_e;

    state_e             state_q, state_d;
    logic [BIT_LEN-1:0] shift_q, shift_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               par_q, par_d;
    logic               stop1_q, stop1_d;
    logic [BIT_LEN-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;

    // State and datapath registers, cleared asynchronously by rstn
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            stop1_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            stop1_q <= stop1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state and capture logic; the result is published on the STOP2 edge
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        stop1_d = stop1_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        case (state_q)
            IDLE: begin
                if (channel_in) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                par_d   = channel_in;
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                shift_d[cnt_q] = channel_in;
                cnt_d          = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = STOP1;
                end
            end
            STOP1: begin
                stop1_d = channel_in;
                state_d = STOP2;
            end
            STOP2: begin
                data_d  = shift_q;
                perr_d  = par_q ^ (^shift_q);
                ferr_d  = ~(stop1_q & channel_in);
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rx_frame_receiver.sv
// Self-checking bench for rx_frame_receiver: builds a line bitstream from frame
// records and predicts every output cycle by cycle from the frame timing rules.
module tb_rx_frame_receiver;

    localparam int BL = 7;
    localparam int FL = BL + 4;

    typedef struct {
        int          start;
        logic [BL-1:0] d;
        bit          perr;
        bit          ferr;
    } frm_t;

    logic          clk;
    logic          rstn;
    logic          channel_in;
    logic [BL-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic  stream[$];
    frm_t  frames[$];
    logic [BL-1:0] hd;
    bit    hp;
    bit    hf;

    rx_frame_receiver #(.BIT_LEN(BL)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .channel_in (channel_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic add_frame(input logic [BL-1:0] d, input bit bad_par,
                             input bit s1, input bit s2, input int gap);
        frm_t f;
        f.start = stream.size();
        f.d     = d;
        f.perr  = bad_par;
        f.ferr  = !(s1 && s2);
        frames.push_back(f);
        stream.push_back(1'b1);
        stream.push_back((^d) ^ bad_par);
        for (int i = 0; i < BL; i++) stream.push_back(d[i]);
        stream.push_back(s1);
        stream.push_back(s2);
        for (int i = 0; i < gap; i++) stream.push_back(1'b0);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) stream.push_back(1'b0);
    endtask

    // Bit k of the stream is sampled at edge k; a frame starting at edge s
    // keeps busy high after edges s..s+BL+2 and pulses valid after edge s+BL+3.
    task automatic run_stream();
        int vmap[int];
        bit bmap[int];
        int n;
        foreach (frames[i]) begin
            vmap[frames[i].start + BL + 3] = i;
            for (int e = frames[i].start; e <= frames[i].start + BL + 2; e++) bmap[e] = 1'b1;
        end
        n = stream.size() + FL + 2;
        for (int k = 0; k < n; k++) begin
            channel_in = (k < stream.size()) ? stream[k] : 1'b0;
            @(posedge clk);
            #1;
            if (vmap.exists(k)) begin
                hd = frames[vmap[k]].d;
                hp = frames[vmap[k]].perr;
                hf = frames[vmap[k]].ferr;
            end
            check("valid", 32'(data_valid), 32'(vmap.exists(k)));
            check("busy", 32'(busy), 32'(bmap.exists(k)));
            check("data", 32'(data_out), 32'(hd));
            check("parity_err", 32'(parity_err), 32'(hp));
            check("frame_err", 32'(frame_err), 32'(hf));
        end
        channel_in = 1'b0;
        stream.delete();
        frames.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(data_out), 32'd0);
        check({tag, "_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_perr"}, 32'(parity_err), 32'd0);
        check({tag, "_ferr"}, 32'(frame_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [BL-1:0] ad;
        logic          abits[5];

        rstn       = 1'b0;
        channel_in = 1'b0;
        hd = '0;
        hp = 1'b0;
        hf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Idle line: nothing may happen
        add_idle(20);
        run_stream();

        // Directed frames
        add_frame(7'h55, 1'b0, 1'b1, 1'b1, 1);
        add_frame(7'h01, 1'b1, 1'b1, 1'b1, 2);
        add_frame(7'h7F, 1'b0, 1'b1, 1'b0, 1);
        add_frame(7'h2A, 1'b0, 1'b1, 1'b1, 3);
        add_frame(7'h12, 1'b0, 1'b1, 1'b1, 0);
        add_frame(7'h6C, 1'b0, 1'b1, 1'b1, 2);
        add_frame(7'h12, 1'b0, 1'b1, 1'b1, 1);
        add_frame(7'h6C, 1'b0, 1'b1, 1'b1, 2);
        add_frame(7'h00, 1'b0, 1'b0, 1'b1, 1);
        run_stream();

        // Line stuck high: back-to-back all-ones frames
        for (int i = 0; i < 4; i++) add_frame('1, 1'b0, 1'b1, 1'b1, 0);
        add_idle(2);
        run_stream();

        // Randomized frames with random errors and gaps
        for (int i = 0; i < 60; i++) begin
            add_frame(BL'($urandom), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                      $urandom_range(0, 3));
        end
        run_stream();

        // Make sure data_out is non-zero so the reset clear is observable
        add_frame(7'h5A, 1'b1, 1'b0, 1'b1, 1);
        run_stream();

        // Abort a frame with reset while data bit 3 is on the line
        ad = 7'h4B;
        abits[0] = 1'b1;
        abits[1] = ^ad;
        abits[2] = ad[0];
        abits[3] = ad[1];
        abits[4] = ad[2];
        for (int k = 0; k < 5; k++) begin
            channel_in = abits[k];
            @(posedge clk);
            #1;
            check("abort_valid", 32'(data_valid), 32'd0);
            check("abort_busy", 32'(busy), 32'd1);
        end
        channel_in = ad[3];
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("abort_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("abort_hold");
        channel_in = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        hd = '0;
        hp = 1'b0;
        hf = 1'b0;
        add_idle(1);
        add_frame(7'h33, 1'b0, 1'b1, 1'b1, 1);
        run_stream();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
